// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a simple-dual-port BRAM: write channel (port A) and read channel (port B)
// arbitrated independently. Define ARB_ROUND_ROBIN_EN for round-robin; otherwise r0 has fixed priority.
module bram_port_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          ena,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina,
    output logic          enb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] doutb
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Index 0 = write channel (port A), index 1 = read channel (port B)
    logic [1:0][1:0]    st_q, st_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         ho_q, ho_d;
    logic [1:0]         hid_q, hid_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]         ptr_q, ptr_d;
`endif
    logic [1:0][1:0]    req_ch;
    logic [1:0]         lock_v;
    logic [1:0]         gnt_ch;
    logic [1:0]         gid;
    logic [RD_LAT-1:0][1:0] rpipe_q;

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            cnt_q <= '0;
            ho_q  <= '0;
            hid_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= '0;
`endif
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            ho_q  <= ho_d;
            hid_q <= hid_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    // Grant selection and next state; channel A resolves first so B can detect a same-address collision
    always_comb begin : p_arb
        logic          want;
        logic          id;
        logic          both;
        logic          collide;
        logic [CW-1:0] cnt_nxt;

        req_ch[0] = {r1_req & r1_we,  r0_req & r0_we};
        req_ch[1] = {r1_req & ~r1_we, r0_req & ~r0_we};
        lock_v    = {r1_lock, r0_lock};
        gnt_ch    = '0;
        gid       = '0;
        st_d      = st_q;
        cnt_d     = cnt_q;
        ho_d      = ho_q;
        hid_d     = hid_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        want      = 1'b0;
        id        = 1'b0;
        both      = 1'b0;
        collide   = 1'b0;
        cnt_nxt   = '0;

        for (int c = 0; c < 2; c++) begin
            want = 1'b0;
            id   = 1'b0;
            both = &req_ch[c];
            case (st_q[c])
                ST_OWN0: begin
                    id   = 1'b0;
                    want = req_ch[c][0];
                end
                ST_OWN1: begin
                    id   = 1'b1;
                    want = req_ch[c][1];
                end
                default: begin
                    want = |req_ch[c];
                    if (both) begin
`ifdef ARB_ROUND_ROBIN_EN
                        id = ho_q[c] ? hid_q[c] : ptr_q[c];
`else
                        id = ho_q[c] ? hid_q[c] : 1'b0;
`endif
                    end else begin
                        id = req_ch[c][1];
                    end
                end
            endcase

            collide = (c == 1) && gnt_ch[0] &&
                      ((gid[0] ? r1_addr : r0_addr) == (id ? r1_addr : r0_addr));
            gid[c]  = id;

            if (want && !collide) begin
                gnt_ch[c] = 1'b1;
                ho_d[c]   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                if (st_q[c] == ST_FREE && both) ptr_d[c] = ~id;
`endif
                if (st_q[c] == ST_FREE)
                    cnt_nxt = CW'(1);
                else if (cnt_q[c] == CW'(MAX_BURST))
                    cnt_nxt = cnt_q[c];
                else
                    cnt_nxt = cnt_q[c] + CW'(1);

                if (!lock_v[id]) begin
                    st_d[c]  = ST_FREE;
                    cnt_d[c] = '0;
                end else if (cnt_nxt == CW'(MAX_BURST) && req_ch[c][~id]) begin
                    // Burst limit reached with the other side waiting: hand it the next grant
                    st_d[c]  = ST_FREE;
                    cnt_d[c] = '0;
                    ho_d[c]  = 1'b1;
                    hid_d[c] = ~id;
                end else begin
                    st_d[c]  = id ? ST_OWN1 : ST_OWN0;
                    cnt_d[c] = cnt_nxt;
                end
            end else if (st_q[c] != ST_FREE) begin
                if (!req_ch[c][id] || !lock_v[id]) begin
                    st_d[c]  = ST_FREE;
                    cnt_d[c] = '0;
                end
            end else if (ho_q[c] && !req_ch[c][hid_q[c]]) begin
                ho_d[c] = 1'b0;
            end
        end
    end

    // Read-return tag pipe, one-hot per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpipe_q <= '0;
        end else begin
            rpipe_q[0] <= {gnt_ch[1] & gid[1], gnt_ch[1] & ~gid[1]};
            for (int i = 1; i < RD_LAT; i++) rpipe_q[i] <= rpipe_q[i-1];
        end
    end

    assign r0_gnt    = rst_n & ((gnt_ch[0] & ~gid[0]) | (gnt_ch[1] & ~gid[1]));
    assign r1_gnt    = rst_n & ((gnt_ch[0] &  gid[0]) | (gnt_ch[1] &  gid[1]));
    assign ena       = rst_n & gnt_ch[0];
    assign wea       = rst_n & gnt_ch[0];
    assign addra     = ena ? (gid[0] ? r1_addr  : r0_addr)  : '0;
    assign dina      = ena ? (gid[0] ? r1_wdata : r0_wdata) : '0;
    assign enb       = rst_n & gnt_ch[1];
    assign addrb     = enb ? (gid[1] ? r1_addr : r0_addr) : '0;
    assign r0_rvalid = rpipe_q[RD_LAT-1][0];
    assign r1_rvalid = rpipe_q[RD_LAT-1][1];
    assign r0_rdata  = rst_n ? doutb : '0;
    assign r1_rdata  = rst_n ? doutb : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a RD_LAT=1 instance with a BRAM model, plus a RD_LAT=2
// instance sharing the same inputs for the reset-during-read case.
module tb_bram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_req, r0_we, r0_lock;
    logic [9:0] r0_addr;
    logic [7:0] r0_wdata;
    logic       r1_req, r1_we, r1_lock;
    logic [9:0] r1_addr;
    logic [7:0] r1_wdata;
    logic [7:0] doutb;

    logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, ena, wea, enb;
    logic [7:0] r0_rdata, r1_rdata, dina;
    logic [9:0] addra, addrb;

    logic       l2_r0_gnt, l2_r0_rvalid, l2_r1_gnt, l2_r1_rvalid, l2_ena, l2_wea, l2_enb;
    logic [7:0] l2_r0_rdata, l2_r1_rdata, l2_dina;
    logic [9:0] l2_addra, l2_addrb;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [1024];

    always #5 clk = ~clk;

    // BRAM model with one cycle read latency
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb];
    end

    bram_port_arbiter #(.AW(10), .DW(8), .RD_LAT(1), .MAX_BURST(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb)
    );

    bram_port_arbiter #(.AW(10), .DW(8), .RD_LAT(2), .MAX_BURST(16)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(l2_r0_gnt), .r0_rvalid(l2_r0_rvalid), .r0_rdata(l2_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(l2_r1_gnt), .r1_rvalid(l2_r1_rvalid), .r1_rdata(l2_r1_rdata),
        .ena(l2_ena), .wea(l2_wea), .addra(l2_addra), .dina(l2_dina),
        .enb(l2_enb), .addrb(l2_addrb), .doutb(doutb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [49:0] obs;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ena, wea, addra, dina, enb, addrb};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", obs);
        end
        step();
        rst_n = 1;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ena, wea, addra, dina, enb, addrb};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h required 0", obs);
        end
    endtask

    task automatic test_read_return();
        logic [20:0] obs;
        // Preload address 5 through the write channel
        step();
        r0_req = 1; r0_we = 1; r0_addr = 10'd5; r0_wdata = 8'h3C;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, addra, dina};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 10'd5, 8'h3C}) begin
            errors++;
            $display("FAIL preload_write: got %h required %h", obs, {1'b1, 1'b0, 1'b1, 10'd5, 8'h3C});
        end
        step();
        r0_we = 0;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, enb, addrb, 8'h00};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 10'd5, 8'h00} || ena !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: got %h ena %b required %h ena 0", obs, ena, {1'b1, 1'b0, 1'b1, 10'd5, 8'h00});
        end
        step();
        r0_req = 0;
        @(negedge clk);
        checks++;
        if ({r0_rvalid, r1_rvalid, r0_rdata} !== {1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL read_return: got rvalid0 %b rvalid1 %b rdata %h required 1 0 3c", r0_rvalid, r1_rvalid, r0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_single_pulse: got %b required 0", r0_rvalid);
        end
    endtask

    task automatic test_write_rr();
        logic [21:0] obs;
        logic [21:0] exp;
        do_reset();
        r0_req = 1; r0_we = 1; r0_addr = 10'd1; r0_wdata = 8'h11;
        r1_req = 1; r1_we = 1; r1_addr = 10'd2; r1_wdata = 8'h22;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, wea, addra, dina};
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 10'd1, 8'h11};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL contend_first: got %h required %h", obs, exp);
        end
        step();
        r0_req = 0;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, wea, addra, dina};
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 10'd2, 8'h22};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL contend_second: got %h required %h", obs, exp);
        end
        step();
        r0_req = 1; r0_addr = 10'd3; r0_wdata = 8'h33;
        r1_addr = 10'd4; r1_wdata = 8'h44;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, wea, addra, dina};
`ifdef ARB_ROUND_ROBIN_EN
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 10'd4, 8'h44};
`else
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 10'd3, 8'h33};
`endif
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL next_contention: got %h required %h", obs, exp);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_collision();
        logic [23:0] obs;
        logic [23:0] exp;
        r0_req = 1; r0_we = 1; r0_addr = 10'd7; r0_wdata = 8'hAA;
        r1_req = 1; r1_we = 0; r1_addr = 10'd7;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, addra, enb, addrb};
        exp = {1'b1, 1'b0, 1'b1, 10'd7, 1'b0, 10'd0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL collision_withhold: got %h required %h", obs, exp);
        end
        step();
        r0_req = 0;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, addra, enb, addrb};
        exp = {1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 10'd7};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL collision_retry: got %h required %h", obs, exp);
        end
        step();
        r1_req = 0;
        @(negedge clk);
        checks++;
        if ({r0_rvalid, r1_rvalid, r1_rdata} !== {1'b0, 1'b1, 8'hAA}) begin
            errors++;
            $display("FAIL collision_new_data: got rvalid0 %b rvalid1 %b rdata %h required 0 1 aa", r0_rvalid, r1_rvalid, r1_rdata);
        end
        // Different addresses: write and read both issue in the same cycle
        step();
        r0_req = 1; r0_we = 1; r0_addr = 10'd8; r0_wdata = 8'h55;
        r1_req = 1; r1_we = 0; r1_addr = 10'd7;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, ena, addra, enb, addrb};
        exp = {1'b1, 1'b1, 1'b1, 10'd8, 1'b1, 10'd7};
        checks++;
        if (obs !== exp || dina !== 8'h55) begin
            errors++;
            $display("FAIL simultaneous_wr_rd: got %h dina %h required %h dina 55", obs, dina, exp);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({r1_rvalid, r1_rdata} !== {1'b1, 8'hAA}) begin
            errors++;
            $display("FAIL simultaneous_return: got rvalid1 %b rdata %h required 1 aa", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_burst_handoff();
        logic [11:0] obs;
        do_reset();
        r0_req = 1; r0_we = 0; r0_lock = 1; r0_addr = 10'd10;
        r1_req = 1; r1_we = 0; r1_lock = 0; r1_addr = 10'd11;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) step();
            @(negedge clk);
            obs = {r0_gnt, r1_gnt, addrb};
            checks++;
            if (obs !== {1'b1, 1'b0, 10'd10}) begin
                errors++;
                $display("FAIL burst_grant_%0d: got %h required %h", k, obs, {1'b1, 1'b0, 10'd10});
            end
        end
        step();
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, addrb};
        checks++;
        if (obs !== {1'b0, 1'b1, 10'd11}) begin
            errors++;
            $display("FAIL burst_handoff: got %h required %h", obs, {1'b0, 1'b1, 10'd11});
        end
        step();
        r1_req = 0;
        @(negedge clk);
        obs = {r0_gnt, r1_gnt, addrb};
        checks++;
        if (obs !== {1'b1, 1'b0, 10'd10}) begin
            errors++;
            $display("FAIL burst_resume: got %h required %h", obs, {1'b1, 1'b0, 10'd10});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp;
        do_reset();
        r0_req = 1; r0_we = 0; r0_lock = 0; r0_addr = 10'd20;
        r1_req = 1; r1_we = 0; r1_lock = 0; r1_addr = 10'd21;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            checks++;
            if ({r0_gnt, r1_gnt} !== exp) begin
                errors++;
                $display("FAIL priority_cycle_%0d: got %b required %b", k, {r0_gnt, r1_gnt}, exp);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        logic [50:0] obs;
        step();
        r0_req = 1; r0_we = 0; r0_addr = 10'd5;
        @(negedge clk);
        checks++;
        if (l2_r0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lat2_read_grant: got %b required 1", l2_r0_gnt);
        end
        step();
        rst_n = 0;
        @(negedge clk);
        obs = {l2_r0_gnt, l2_r1_gnt, l2_r0_rvalid, l2_r1_rvalid, l2_r0_rdata, l2_r1_rdata,
               l2_ena, l2_wea, l2_addra, l2_dina, l2_enb, l2_addrb};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL outputs_in_reset: got %h required 0", obs);
        end
        checks++;
        if ({r0_gnt, r0_rvalid, enb, addrb} !== '0) begin
            errors++;
            $display("FAIL lat1_outputs_in_reset: got %h required 0", {r0_gnt, r0_rvalid, enb, addrb});
        end
        step();
        rst_n = 1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({l2_r0_rvalid, l2_r1_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL no_rvalid_after_reset_%0d: got %b required 00", k, {l2_r0_rvalid, l2_r1_rvalid});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_read_return();
        test_write_rr();
        test_collision();
        test_burst_handoff();
        test_fixed_priority();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
